// File: rtl/com_rx.sv
// com link receiver: 8N1 deserialiser plus AA 55 framed-packet parser.
// Good payloads are buffered and streamed out; bad frames raise error pulses.
module com_rx #(
   parameter int BAUD_DIV = 16,
   parameter int MAX_LEN  = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] odata,
   output logic       ovalid,
   output logic       olast,
   input  logic       oready,
   output logic       frame_ok,
   output logic       err_chk,
   output logic       err_len,
   output logic       err_stop,
   output logic       err_ovf
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
   localparam logic [7:0] MAXL = 8'(MAX_LEN);

   typedef enum logic [1:0] {
      B_IDLE,
      B_START,
      B_DATA,
      B_STOP
   } bstate_t;

   typedef enum logic [2:0] {
      F_H0,
      F_H1,
      F_LEN,
      F_PAY,
      F_CHK,
      F_DRAIN
   } fstate_t;

   logic          rx_m;
   logic          rx_s;
   logic          rx_d;
   bstate_t       bs;
   bstate_t       bs_nx;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          byte_stb;
   logic          tick;

   fstate_t       fs;
   fstate_t       fs_nx;
   logic [7:0]    len;
   logic [7:0]    sum;
   logic [7:0]    idx;
   logic [7:0]    rd;
   logic          last_rd;
   logic [7:0]    mem [MAX_LEN];

   // rx_d gives the previous synchronised level for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   always_comb begin
      tick = (cnt == ((bs == B_START) ? HALF : FULL));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) bs <= B_IDLE;
      else      bs <= bs_nx;
   end

   always_comb begin
      bs_nx = bs;
      unique case (bs)
         B_IDLE:  if (rx_d && !rx_s) bs_nx = B_START;
         B_START: if (tick) bs_nx = rx_s ? B_IDLE : B_DATA;
         B_DATA:  if (tick && bit_idx == 3'd7) bs_nx = B_STOP;
         B_STOP:  if (tick) bs_nx = B_IDLE;
         default: bs_nx = B_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         byte_stb <= 1'b0;
         err_stop <= 1'b0;
      end else begin
         byte_stb <= 1'b0;
         err_stop <= 1'b0;
         if (bs == B_IDLE || tick) cnt <= '0;
         else                      cnt <= cnt + 1'b1;
         if (bs == B_DATA && tick) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
         if (bs == B_STOP && tick) begin
            byte_stb <= rx_s;
            err_stop <= !rx_s;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) fs <= F_H0;
      else      fs <= fs_nx;
   end

   always_comb begin
      fs_nx    = fs;
      frame_ok = 1'b0;
      err_chk  = 1'b0;
      err_len  = 1'b0;
      err_ovf  = 1'b0;
      ovalid   = (fs == F_DRAIN);
      last_rd  = (rd == len - 8'd1);
      olast    = ovalid && last_rd;
      odata    = ovalid ? mem[rd[AW-1:0]] : 8'd0;
      unique case (fs)
         F_H0: if (byte_stb && shreg == 8'hAA) fs_nx = F_H1;
         F_H1: begin
            if (byte_stb) begin
               if (shreg == 8'h55)      fs_nx = F_LEN;
               else if (shreg == 8'hAA) fs_nx = F_H1;
               else                     fs_nx = F_H0;
            end
         end
         F_LEN: begin
            if (byte_stb) begin
               if (shreg != 8'd0 && shreg <= MAXL) begin
                  fs_nx = F_PAY;
               end else begin
                  err_len = 1'b1;
                  fs_nx   = F_H0;
               end
            end
         end
         F_PAY: if (byte_stb && idx == len - 8'd1) fs_nx = F_CHK;
         F_CHK: begin
            if (byte_stb) begin
               if (shreg == sum) begin
                  frame_ok = 1'b1;
                  fs_nx    = F_DRAIN;
               end else begin
                  err_chk = 1'b1;
                  fs_nx   = F_H0;
               end
            end
         end
         F_DRAIN: begin
            err_ovf = byte_stb;
            if (oready && last_rd) fs_nx = F_H0;
         end
         default: fs_nx = F_H0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len <= '0;
         sum <= '0;
         idx <= '0;
         rd  <= '0;
      end else begin
         if (fs == F_LEN && byte_stb) begin
            len <= shreg;
            sum <= shreg;
            idx <= '0;
         end
         if (fs == F_PAY && byte_stb) begin
            sum <= sum + shreg;
            idx <= idx + 8'd1;
         end
         if (fs == F_CHK) rd <= '0;
         if (fs == F_DRAIN && oready) rd <= rd + 8'd1;
      end
   end

   // payload store is plain registers; no reset needed
   always_ff @(posedge clk) begin
      if (fs == F_PAY && byte_stb) mem[idx[AW-1:0]] <= shreg;
   end

endmodule

// File: tb/tb_com_rx.sv
// Bench for com_rx: serial frames driven on rx, expected beats and
// event pulses queued by a frame-level model and checked by a monitor.
module tb_com_rx;

   localparam int BD   = 16;
   localparam int MAXL = 64;
   localparam int EV_OK   = 1;
   localparam int EV_CHK  = 2;
   localparam int EV_LEN  = 3;
   localparam int EV_STOP = 4;
   localparam int EV_OVF  = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] odata;
   logic       ovalid;
   logic       olast;
   logic       oready = 1'b1;
   logic       frame_ok;
   logic       err_chk;
   logic       err_len;
   logic       err_stop;
   logic       err_ovf;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [8:0] exp_q [$];
   int         ev_q [$];
   logic [7:0] pay [256];
   int         rdy_mode = 0;
   int         cyc = 0;

   logic       stall = 1'b0;
   logic [7:0] st_data = 8'd0;
   logic       st_last = 1'b0;
   logic       ok_next = 1'b0;

   com_rx #(.BAUD_DIV(BD), .MAX_LEN(MAXL)) dut (
      .clk(clk), .rst(rst), .rx(rx),
      .odata(odata), .ovalid(ovalid), .olast(olast), .oready(oready),
      .frame_ok(frame_ok), .err_chk(err_chk), .err_len(err_len),
      .err_stop(err_stop), .err_ovf(err_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   // oready patterns: 0 always, 1 repeating 1,0,0,1, 2 held low, 3 random
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         case (rdy_mode)
            0: oready = 1'b1;
            1: oready = (cyc % 4 == 0) || (cyc % 4 == 3);
            2: oready = 1'b0;
            default: oready = 1'($urandom % 2);
         endcase
      end
   end

   always @(negedge clk) begin
      int np;
      int code;
      logic [8:0] e;
      if (!rst) begin
         check("reset_outs", 32'({odata, ovalid, olast, frame_ok, err_chk,
               err_len, err_stop, err_ovf}), 32'd0);
         stall   = 1'b0;
         ok_next = 1'b0;
      end else begin
         if (ok_next) check("valid_after_ok", 32'(ovalid), 32'd1);
         if (stall)
            check("stall_hold", 32'({ovalid, odata, olast}),
                  32'({1'b1, st_data, st_last}));
         np = int'(frame_ok) + int'(err_chk) + int'(err_len)
            + int'(err_stop) + int'(err_ovf);
         code = frame_ok ? EV_OK : err_chk ? EV_CHK : err_len ? EV_LEN
              : err_stop ? EV_STOP : EV_OVF;
         if (np > 1) begin
            check("pulse_exclusive", 32'(np), 32'd1);
         end else if (np == 1) begin
            if (ev_q.size() == 0) check("unexpected_event", 32'(code), 32'd0);
            else check("event", 32'(code), 32'(ev_q.pop_front()));
         end
         if (frame_ok) check("valid_at_ok", 32'(ovalid), 32'd0);
         ok_next = frame_ok;
         if (ovalid && oready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 32'({odata, olast}), 32'h1ff);
            end else begin
               e = exp_q.pop_front();
               check("beat", 32'({odata, olast}), 32'(e));
            end
         end
         stall   = ovalid && !oready;
         st_data = odata;
         st_last = olast;
      end
   end

   task automatic send_bit(input logic v);
      rx = v;
      repeat (BD) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
      send_bit(1'b1);
   endtask

   // frame-level model: checksum is LEN plus all payload bytes mod 256
   task automatic send_frame(input int n, input logic [7:0] chk_xor);
      int s;
      logic [7:0] c;
      if (n < 1 || n > MAXL) begin
         ev_q.push_back(EV_LEN);
         send_byte(8'hAA, 1'b1);
         send_byte(8'h55, 1'b1);
         send_byte(8'(n), 1'b1);
      end else begin
         s = n;
         for (int i = 0; i < n; i++) s += int'(pay[i]);
         c = 8'(s % 256) ^ chk_xor;
         if (chk_xor == 8'd0) begin
            ev_q.push_back(EV_OK);
            for (int i = 0; i < n; i++)
               exp_q.push_back({pay[i], i == n - 1});
         end else begin
            ev_q.push_back(EV_CHK);
         end
         send_byte(8'hAA, 1'b1);
         send_byte(8'h55, 1'b1);
         send_byte(8'(n), 1'b1);
         for (int i = 0; i < n; i++) send_byte(pay[i], 1'b1);
         send_byte(c, 1'b1);
      end
   endtask

   task automatic wait_drain(input string nm);
      for (int i = 0; i < 4000; i++) begin
         if (exp_q.size() == 0 && ev_q.size() == 0 && !ovalid) break;
         @(posedge clk);
      end
      #1;
      check(nm, 32'({exp_q.size() != 0, ev_q.size() != 0, ovalid}), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      exp_q.delete();
      ev_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      logic [7:0] s;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
      send_frame(3, 8'h00);
      wait_drain("t1_good");

      send_frame(3, 8'h01);
      wait_drain("t2_badchk");
      send_frame(3, 8'h00);
      wait_drain("t2_good");

      send_frame(0, 8'h00);
      send_frame(65, 8'h00);
      wait_drain("t3_len");
      ev_q.push_back(EV_OK);
      exp_q.push_back({8'h7E, 1'b1});
      send_byte(8'hAA, 1'b1);
      send_byte(8'hAA, 1'b1);
      send_byte(8'h55, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h7E, 1'b1);
      send_byte(8'h7F, 1'b1);
      wait_drain("t3_hunt");

      // receiver sees payload 11,33,chk and then the filler as CHK
      s = 8'(3 + 'h11 + 'h22 + 'h33);
      ev_q.push_back(EV_STOP);
      ev_q.push_back(EV_CHK);
      send_byte(8'hAA, 1'b1);
      send_byte(8'h55, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b1);
      send_byte(s, 1'b1);
      send_byte(8'(3 + 'h11 + 'h33 + int'(s)) ^ 8'hFF, 1'b1);
      wait_drain("t4_stop");
      rx = 1'b0;
      repeat (BD / 4) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (BD * 24) @(posedge clk);
      #1;
      wait_drain("t4_glitch");

      rdy_mode = 1;
      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
      send_frame(64, 8'h00);
      wait_drain("t5_stall");
      rdy_mode = 2;
      for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
      send_frame(4, 8'h00);
      for (int i = 0; i < 3; i++) begin
         ev_q.push_back(EV_OVF);
         send_byte((i == 0) ? 8'hAA : (i == 1) ? 8'h55 : 8'h02, 1'b1);
      end
      rdy_mode = 1;
      wait_drain("t5_ovf");

      rdy_mode = 0;
      send_byte(8'hAA, 1'b1);
      send_byte(8'h55, 1'b1);
      send_byte(8'h05, 1'b1);
      send_byte(8'h10, 1'b1);
      do_reset();
      rdy_mode = 2;
      for (int i = 0; i < 8; i++) pay[i] = 8'(i * 7 + 1);
      send_frame(8, 8'h00);
      check("t6_draining", 32'(ovalid), 32'd1);
      do_reset();
      rdy_mode = 0;
      send_frame(8, 8'h00);
      wait_drain("t6_after");

      for (int f = 0; f < 6; f++) begin
         rdy_mode = 3;
         n = ($urandom % 8 == 0) ? 65 : int'($urandom_range(1, 24));
         for (int i = 0; i < n && i < 256; i++) pay[i] = 8'($urandom);
         send_frame(n, ($urandom % 3 == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
         wait_drain("rand_frame");
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
